// File: rtl/button_gesture_decoder.sv
// ---------------------------------------------------------------------------
// button_gesture_decoder
//
// Classifies gestures on a debounced, clk-synchronous push-button level:
//   press / release edges, short press, long press and double click.
// Every result is a registered single-cycle pulse.
//
// Optional feature: define AUTO_REPEAT_EN to build the auto-repeat counter
// that pulses repeat_pulse every REPEAT_CLOCKS cycles while a long press is
// still held. Without the macro repeat_pulse is tied to 0 and the repeat
// counter does not exist.
//
// Reset is asynchronous and active low. A gesture that reset interrupts never
// produces a gesture pulse, because the FSM and counters restart from IDLE.
//
// Handshake: there is no valid/ready pair. btn is sampled every rising clk
// edge and every output is a level (held) or a one-cycle pulse that the
// consumer must capture in the cycle it is high; nothing is back-pressured.
// ---------------------------------------------------------------------------
module button_gesture_decoder #(
  parameter int LONG_CLOCKS   = 12_000_000,
  parameter int DOUBLE_CLOCKS = 3_600_000,
  parameter int REPEAT_CLOCKS = 1_200_000,
  parameter int CNT_W         = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic       held,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_press,
  output logic       long_press,
  output logic       double_click,
  output logic       repeat_pulse,
  output logic [2:0] dbg_state
);

  // FSM encoding
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRESSED  = 3'd1;
  localparam logic [2:0] S_LONGHELD = 3'd2;
  localparam logic [2:0] S_WAIT2    = 3'd3;
  localparam logic [2:0] S_PRESS2   = 3'd4;

  // Terminal counts: the counter starts at 0 on state entry, so the limit is
  // reached on the (LIMIT)-th cycle spent in the state.
  localparam logic [CNT_W-1:0] C_LONG_LAST   = CNT_W'(LONG_CLOCKS - 1);
  localparam logic [CNT_W-1:0] C_DOUBLE_LAST = CNT_W'(DOUBLE_CLOCKS - 1);

  // Largest count any timer has to reach; used only for the width check.
  localparam int MAX_CLOCKS_LD = (LONG_CLOCKS > DOUBLE_CLOCKS) ? LONG_CLOCKS : DOUBLE_CLOCKS;
  localparam int MAX_CLOCKS    = (MAX_CLOCKS_LD > REPEAT_CLOCKS) ? MAX_CLOCKS_LD : REPEAT_CLOCKS;

  // Refuse to elaborate if a timer could not reach its terminal count.
  if (longint'(MAX_CLOCKS) > (longint'(1) << CNT_W)) begin : g_bad_cnt_w
    $error("button_gesture_decoder: CNT_W too narrow for the configured clock counts");
  end

  // ---------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------
  logic             r_btn_q;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press_pulse;
  logic             r_release_pulse;
  logic             r_short_press;
  logic             r_long_press;
  logic             r_double_click;

  logic             w_rise;
  logic             w_fall;
  logic [2:0]       w_state_nxt;
  logic             w_long_nxt;
  logic             w_short_nxt;
  logic             w_double_nxt;
  logic             w_timed_state;

  // Edge detection against the previous sample.
  assign w_rise = btn & ~r_btn_q;
  assign w_fall = ~btn & r_btn_q;

  // Only PRESSED and WAIT2 compare the counter; elsewhere it rests at 0 so
  // it cannot wrap however long the button sits idle or long-held.
  assign w_timed_state = (r_state == S_PRESSED) || (r_state == S_WAIT2);

  // Button sample register; its value is also the held output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_q <= 1'b0;
    end else begin
      r_btn_q <= btn;
    end
  end

  // Next-state and gesture-pulse decode. Where an edge and a timeout land in
  // the same cycle the edge is tested first, so it wins.
  always_comb begin
    w_state_nxt  = r_state;
    w_long_nxt   = 1'b0;
    w_short_nxt  = 1'b0;
    w_double_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_PRESSED;
        end
      end
      S_PRESSED: begin
        if (w_fall) begin
          w_state_nxt = S_WAIT2;
        end else if (r_cnt == C_LONG_LAST) begin
          // btn is necessarily still 1 here: no fall since the press edge.
          w_long_nxt  = 1'b1;
          w_state_nxt = S_LONGHELD;
        end
      end
      S_LONGHELD: begin
        if (w_fall) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT2: begin
        if (w_rise) begin
          w_double_nxt = 1'b1;
          w_state_nxt  = S_PRESS2;
        end else if (r_cnt == C_DOUBLE_LAST) begin
          w_short_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_PRESS2: begin
        if (w_fall) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Gesture timer: cleared on every state change, counts in timed states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (w_timed_state) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Registered output pulses; edges fire regardless of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_short_press   <= 1'b0;
      r_long_press    <= 1'b0;
      r_double_click  <= 1'b0;
    end else begin
      r_press_pulse   <= w_rise;
      r_release_pulse <= w_fall;
      r_short_press   <= w_short_nxt;
      r_long_press    <= w_long_nxt;
      r_double_click  <= w_double_nxt;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] C_REPEAT_LAST = CNT_W'(REPEAT_CLOCKS - 1);

  logic [CNT_W-1:0] r_rep_cnt;
  logic             r_repeat_pulse;

  // Auto-repeat: counts only while LONGHELD (cleared on entry because the
  // previous cycle was PRESSED); the release cycle itself is still LONGHELD,
  // so a period that ends exactly on release still pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt      <= '0;
      r_repeat_pulse <= 1'b0;
    end else if (r_state == S_LONGHELD) begin
      if (r_rep_cnt == C_REPEAT_LAST) begin
        r_rep_cnt      <= '0;
        r_repeat_pulse <= 1'b1;
      end else begin
        r_rep_cnt      <= r_rep_cnt + 1'b1;
        r_repeat_pulse <= 1'b0;
      end
    end else begin
      r_rep_cnt      <= '0;
      r_repeat_pulse <= 1'b0;
    end
  end

  assign repeat_pulse = r_repeat_pulse;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign held          = r_btn_q;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;
  assign short_press   = r_short_press;
  assign long_press    = r_long_press;
  assign double_click  = r_double_click;
  assign dbg_state     = r_state;

endmodule
